int_div_32: RTL and testbench



---
 rtl/int_div_32_pkg.sv | 18 +
 rtl/int_div_32_div_step.sv | 25 ++
 rtl/int_div_32.sv | 163 ++++++++++++++++
 tb/tb_int_div_32.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/int_div_32_pkg.sv
// Shared encodings and constants for the RV32M iterative divider.
package int_div_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CALC    = 3'd1;
    localparam logic [2:0] S_FIX     = 3'd2;
    localparam logic [2:0] S_SPECIAL = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/int_div_32_div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_dvsr,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;
    logic          w_borrow;

    // rem < dvsr on entry, so the shifted partial remainder fits in XLEN+1 bits
    // and bit XLEN of the difference is set exactly when the subtract borrows.
    assign w_shift  = {i_rem, i_quo[XLEN-1]};
    assign w_diff   = w_shift - {1'b0, i_dvsr};
    assign w_borrow = w_diff[XLEN];

    assign o_rem = w_borrow ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
    assign o_quo = {i_quo[XLEN-2:0], ~w_borrow};

endmodule

// File: rtl/int_div_32.sv
// RV32M DIV/DIVU/REM/REMU radix-2 restoring divider, one operation in flight.
// Define INT_DIV_EARLY_OUT_EN to skip the leading-zero iterations of |dividend|.
module int_div_32
    import int_div_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ITER_CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    logic [2:0]            r_state;
    logic [1:0]            r_op;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic [XLEN-1:0]       r_rem;
    logic [XLEN-1:0]       r_quo;
    logic [XLEN-1:0]       r_dvsr;
    logic [ITER_CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]       r_result;
    logic                  r_out_valid;

    logic                  w_accept;
    logic                  w_signed;
    logic                  w_sgn_a;
    logic                  w_sgn_b;
    logic [XLEN-1:0]       w_mag_a;
    logic [XLEN-1:0]       w_mag_b;
    logic                  w_div0;
    logic                  w_ovf;
    logic [XLEN-1:0]       w_quo_init;
    logic [ITER_CNT_W-1:0] w_cnt_init;
    logic [XLEN-1:0]       w_rem_nxt;
    logic [XLEN-1:0]       w_quo_nxt;
    logic [XLEN-1:0]       w_final;

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign result    = r_result;

    assign w_accept = in_valid && in_ready && !flush;
    assign w_signed = (op == OP_DIV) || (op == OP_REM);
    assign w_sgn_a  = w_signed && dividend[XLEN-1];
    assign w_sgn_b  = w_signed && divisor[XLEN-1];
    assign w_mag_a  = w_sgn_a ? -dividend : dividend;
    assign w_mag_b  = w_sgn_b ? -divisor : divisor;
    assign w_div0   = (divisor == '0);
    assign w_ovf    = w_signed && (dividend == INT_MIN) && (divisor == '1);

`ifdef INT_DIV_EARLY_OUT_EN
    function automatic logic [ITER_CNT_W-1:0] f_clz(input logic [XLEN-1:0] v);
        f_clz = ITER_CNT_W'(XLEN);
        for (int i = 0; i < XLEN; i++) begin
            if (v[i]) f_clz = ITER_CNT_W'(XLEN - 1 - i);
        end
    endfunction

    logic [ITER_CNT_W-1:0] w_clz;
    assign w_clz      = f_clz(w_mag_a);
    assign w_quo_init = w_mag_a << w_clz;
    assign w_cnt_init = ITER_CNT_W'(XLEN) - w_clz;
`else
    assign w_quo_init = w_mag_a;
    assign w_cnt_init = ITER_CNT_W'(XLEN);
`endif

    div_step #(.XLEN(XLEN)) u_step (
        .i_rem  (r_rem),
        .i_quo  (r_quo),
        .i_dvsr (r_dvsr),
        .o_rem  (w_rem_nxt),
        .o_quo  (w_quo_nxt)
    );

    // Special results are loaded with both sign flags clear, so FIX and SPECIAL share this select.
    always_comb begin
        w_final = '0;
        if ((r_op == OP_REM) || (r_op == OP_REMU)) begin
            w_final = r_neg_r ? -r_rem : r_rem;
        end else begin
            w_final = r_neg_q ? -r_quo : r_quo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvsr      <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= op;
                        r_dvsr <= w_mag_b;
                        r_cnt  <= w_cnt_init;
                        if (w_div0) begin
                            r_quo   <= DIV_BY_ZERO_Q;
                            r_rem   <= dividend;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= S_SPECIAL;
                        end else if (w_ovf) begin
                            r_quo   <= INT_MIN;
                            r_rem   <= '0;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= S_SPECIAL;
                        end else begin
                            r_quo   <= w_quo_init;
                            r_rem   <= '0;
                            r_neg_q <= w_sgn_a ^ w_sgn_b;
                            r_neg_r <= w_sgn_a;
                            r_state <= (w_cnt_init == '0) ? S_FIX : S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt - ITER_CNT_W'(1);
                    if (r_cnt == ITER_CNT_W'(1)) r_state <= S_FIX;
                end
                S_FIX, S_SPECIAL: begin
                    r_result    <= w_final;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_div_32.sv
// Randomized self-checking bench for int_div_32 against a plain-arithmetic RV32M model.
module tb_int_div_32;
    import int_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_result = '0;
    bit          exp_pending = 1'b0;

    int_div_32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RV32M semantics from plain integer arithmetic.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        bit is_rem;
        is_rem = o[1];
        sa = $signed(a);
        sb = $signed(b);
        if (b == 0) return is_rem ? a : 32'hFFFF_FFFF;
        if (o == OP_DIV || o == OP_REM) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'h0 : 32'h8000_0000;
            return is_rem ? 32'(sa % sb) : 32'(sa / sb);
        end
        return is_rem ? (a % b) : (a / b);
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] m;
        int bits;
        bit sgn;
        sgn = (o == OP_DIV || o == OP_REM);
        if (b == 0) return 2;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef INT_DIV_EARLY_OUT_EN
        m = (sgn && a[31]) ? (~a + 1) : a;
        bits = 0;
        while (m != 0) begin
            m = m >> 1;
            bits++;
        end
        return 2 + bits;
`else
        m = a;
        bits = 32;
        return 2 + bits;
`endif
    endfunction

    // Output compare: whenever a result is presented it must match the model and block new input.
    always @(negedge clk) begin
        if (out_valid) begin
            if (!exp_pending) begin
                chk("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
            end else begin
                chk("result", result, exp_result);
                chk("in_ready_while_valid", {31'b0, in_ready}, 32'd0);
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
        int w, lat;
        bit seen;
        @(negedge clk);
        in_valid  = 1'b1;
        op        = o;
        dividend  = a;
        divisor   = b;
        out_ready = (hold == 0);
        w = 0;
        while (!in_ready && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("accept_timeout", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_result  = model(o, a, b);
        exp_pending = 1'b1;
        #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        op       = 2'($urandom);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            seen = out_valid;
        end
        chk("latency", 32'(lat), 32'(exp_lat(o, a, b)));
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        exp_pending = 1'b0;
        @(negedge clk);
        chk("out_valid_drop", {31'b0, out_valid}, 32'd0);
        chk("in_ready_after", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic abort_op(input bit use_rst);
        int cnt;
        @(negedge clk);
        chk("abort_in_ready_pre", {31'b0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        op        = OP_DIVU;
        dividend  = 32'd1000;
        divisor   = 32'd7;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        flush = 1'b0;
        #1;
        chk(use_rst ? "rst_in_ready" : "flush_in_ready", {31'b0, in_ready}, 32'd1);
        chk(use_rst ? "rst_out_valid" : "flush_out_valid", {31'b0, out_valid}, 32'd0);
        if (use_rst) chk("rst_result_clear", result, 32'd0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk(use_rst ? "rst_no_valid" : "flush_no_valid", 32'(cnt), 32'd0);
    endtask

    logic [1:0]  d_op [12] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_REM, OP_DIVU,
                               OP_REMU, OP_DIV, OP_DIV, OP_REM, OP_DIVU, OP_DIVU};
    logic [31:0] d_a  [12] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'h1234_5678,
                               32'h1234_5678, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd9};
    logic [31:0] d_b  [12] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'd0,
                               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd3};
    logic [31:0] d_q  [12] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF,
                               32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd3};

    function automatic logic [31:0] pick_operand(input bit allow_zero);
        logic [31:0] corner [6] = '{32'd0, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd3};
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = 32'($urandom_range(0, 300));
            2: v = corner[$urandom_range(0, 5)];
            default: v = $urandom >> $urandom_range(0, 31);
        endcase
        if (!allow_zero && v == 0 && $urandom_range(0, 3) != 0) v = 32'd1;
        return v;
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = '0;
        dividend  = '0;
        divisor   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd0);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            chk("model_pin", model(d_op[i], d_a[i], d_b[i]), d_q[i]);
        end

        for (int i = 0; i < 10; i++) begin
            run_op(d_op[i], d_a[i], d_b[i], 0);
        end

        run_op(OP_DIVU, 32'd100, 32'd7, 5);
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 0);

        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        op       = OP_DIVU;
        dividend = 32'd50;
        divisor  = 32'd5;
        @(negedge clk);
        chk("flush_blocks_accept", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b0;
        flush    = 1'b0;

        abort_op(1'b0);
        run_op(OP_DIVU, 32'd9, 32'd3, 0);
        abort_op(1'b1);
        run_op(OP_DIVU, 32'd9, 32'd3, 0);

        for (int i = 0; i < 60; i++) begin
            run_op(2'($urandom), pick_operand(1'b1), pick_operand(1'b0), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
